// File: rtl/sd_pkg.sv
// Shared types and constants for the sudoku solver host (sd_host) and its grid checker.
package sd_pkg;

  localparam int unsigned SD_CELLS     = 81;
  localparam int unsigned SD_MAX_BLANK = 15;
  localparam logic [3:0]  SD_FAIL_CODE = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_RECV,
    ST_CHECK,
    ST_DONE
  } sd_state_e;

  typedef enum logic [1:0] {
    SD_OK      = 2'd0,
    SD_FAIL    = 2'd1,
    SD_ERR     = 2'd2,
    SD_TIMEOUT = 2'd3
  } sd_status_e;

  function automatic logic [3:0] sd_box(input logic [3:0] row, input logic [3:0] col);
    return 4'((row / 4'd3) * 4'd3 + col / 4'd3);
  endfunction

endpackage

// File: rtl/sd_host_if.sv
// Harness-facing bus of sd_host: board loading, run control, status and the solver stream ports.
interface sd_host_if;
  import sd_pkg::*;

  logic       load_valid;
  logic [3:0] load_data;
  logic       start;
  logic       busy;
  logic       sd_in_valid;
  logic [3:0] sd_in;
  logic       sd_out_valid;
  logic [3:0] sd_out;
  logic       done;
  sd_status_e status;

  // master: harness/solver side; slave: sd_host
  modport master (
    output load_valid, load_data, start, sd_out_valid, sd_out,
    input  busy, sd_in_valid, sd_in, done, status
  );

  modport slave (
    input  load_valid, load_data, start, sd_out_valid, sd_out,
    output busy, sd_in_valid, sd_in, done, status
  );

endinterface

// File: rtl/sd_group_check.sv
// Row/column/box occupancy checker for a completed grid, one cell per cycle.
// Built only when SD_HOST_CHECK_EN is defined.
`ifdef SD_HOST_CHECK_EN
module sd_group_check
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] val,
  input  logic [3:0] row,
  input  logic [3:0] col,
  output logic       bad,
  output logic       bad_c
);

  logic [8:0] row_m [9];
  logic [8:0] col_m [9];
  logic [8:0] box_m [9];
  logic [3:0] box;
  logic [8:0] onehot;
  logic       hit;

  // onehot of zero means blank or out-of-range digit
  always_comb begin
    box    = sd_box(row, col);
    onehot = '0;
    if (val >= 4'd1 && val <= 4'd9) onehot = 9'(1) << (val - 4'd1);
    hit    = en && ((onehot == '0) || ((row_m[row] & onehot) != '0) ||
                    ((col_m[col] & onehot) != '0) || ((box_m[box] & onehot) != '0));
    bad_c  = bad | hit;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < 9; i++) begin
        row_m[i] <= '0;
        col_m[i] <= '0;
        box_m[i] <= '0;
      end
      bad <= 1'b0;
    end else if (en) begin
      row_m[row] <= row_m[row] | onehot;
      col_m[col] <= col_m[col] | onehot;
      box_m[box] <= box_m[box] | onehot;
      bad        <= bad | hit;
    end
  end

endmodule
`endif

// File: rtl/sd_host.sv
// Host driver for the sudoku solver: buffers a board, streams it out, merges the answer, reports status.
// Define SD_HOST_CHECK_EN to build the post-solve grid verification pass.
module sd_host
  import sd_pkg::*;
#(
  parameter int unsigned NUM_BLANK = 15,
  parameter int unsigned TIMEOUT   = 100000
) (
  input  logic     clk,
  input  logic     rst,
  sd_host_if.slave bus
);

  localparam int unsigned TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [3:0] NB     = 4'(NUM_BLANK);
  localparam logic [3:0] NB_SAT = 4'(SD_MAX_BLANK);
  localparam logic [6:0] LAST   = 7'(SD_CELLS - 1);

  sd_state_e  state;
  logic [3:0] board [SD_CELLS];
  logic [6:0] blank_pos [SD_MAX_BLANK];
  logic [6:0] lidx;
  logic [6:0] idx;
  logic [3:0] nblank;
  logic [3:0] rcnt;
  logic       err;
  logic       ten;
  logic [TW-1:0] tcnt;

  logic       rx_act, rx_wr, rx_ten, rx_fin, rx_pass;
  sd_status_e rx_code;

`ifdef SD_HOST_CHECK_EN
  logic [3:0] row, col;
  logic       chk_bad, chk_bad_c;

  sd_group_check u_check (
    .clk   (clk),
    .rst   (rst),
    .clr   (state != ST_CHECK),
    .en    (state == ST_CHECK),
    .val   (board[idx]),
    .row   (row),
    .col   (col),
    .bad   (chk_bad),
    .bad_c (chk_bad_c)
  );
`endif

  // classify the solver response word seen this cycle (first word may arrive while in WAIT)
  always_comb begin
    rx_act  = (state == ST_RECV) || (state == ST_WAIT && bus.sd_out_valid);
    rx_wr   = 1'b0;
    rx_ten  = 1'b0;
    rx_fin  = 1'b0;
    rx_pass = 1'b0;
    rx_code = SD_ERR;
    if (rx_act) begin
      if (bus.sd_out_valid) begin
        if (ten) rx_fin = 1'b1;
        else if (rcnt == 4'd0 && bus.sd_out == SD_FAIL_CODE) rx_ten = 1'b1;
        else if (bus.sd_out == 4'd0 || bus.sd_out > 4'd9 || rcnt == NB) rx_fin = 1'b1;
        else rx_wr = 1'b1;
      end else if (ten) begin
        rx_fin  = 1'b1;
        rx_code = SD_FAIL;
      end else if (rcnt != NB || nblank != NB) begin
        rx_fin = 1'b1;
      end else begin
        rx_pass = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      bus.busy        <= 1'b0;
      bus.sd_in_valid <= 1'b0;
      bus.sd_in       <= 4'd0;
      bus.done        <= 1'b0;
      bus.status      <= SD_OK;
      lidx            <= '0;
      idx             <= '0;
      nblank          <= '0;
      rcnt            <= '0;
      err             <= 1'b0;
      ten             <= 1'b0;
      tcnt            <= '0;
      for (int i = 0; i < SD_CELLS; i++) board[i] <= 4'd0;
      for (int i = 0; i < SD_MAX_BLANK; i++) blank_pos[i] <= '0;
`ifdef SD_HOST_CHECK_EN
      row <= '0;
      col <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            lidx            <= '0;
            idx             <= '0;
            nblank          <= '0;
            rcnt            <= '0;
            err             <= 1'b0;
            ten             <= 1'b0;
            bus.busy        <= 1'b1;
            bus.sd_in_valid <= 1'b1;
            bus.sd_in       <= board[0];
            state           <= ST_SEND;
          end else if (bus.load_valid) begin
            board[lidx] <= bus.load_data;
            lidx        <= (lidx == LAST) ? 7'd0 : lidx + 7'd1;
          end
        end
        // record blank positions while streaming so RECV can fill them in order
        ST_SEND: begin
          if (board[idx] == 4'd0 && nblank != NB_SAT) begin
            blank_pos[nblank] <= idx;
            nblank            <= nblank + 4'd1;
          end
          if (bus.sd_out_valid) err <= 1'b1;
          if (idx == LAST) begin
            bus.sd_in_valid <= 1'b0;
            bus.sd_in       <= 4'd0;
            tcnt            <= '0;
            state           <= ST_WAIT;
          end else begin
            idx       <= idx + 7'd1;
            bus.sd_in <= board[idx + 7'd1];
          end
        end
        ST_WAIT: begin
          if (bus.sd_out_valid) begin
            state <= ST_RECV;
          end else if (tcnt == TLAST) begin
            bus.status <= err ? SD_ERR : SD_TIMEOUT;
            bus.done   <= 1'b1;
            state      <= ST_DONE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        ST_RECV: ;
`ifdef SD_HOST_CHECK_EN
        ST_CHECK: begin
          if (idx == LAST) begin
            bus.status <= (err || chk_bad_c) ? SD_ERR : SD_OK;
            bus.done   <= 1'b1;
            state      <= ST_DONE;
          end else begin
            idx <= idx + 7'd1;
            if (col == 4'd8) begin
              col <= 4'd0;
              row <= row + 4'd1;
            end else begin
              col <= col + 4'd1;
            end
          end
        end
`endif
        ST_DONE: begin
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // response handling shared by the first word in WAIT and all of RECV
      if (rx_wr) begin
        if (nblank == NB) board[blank_pos[rcnt]] <= bus.sd_out;
        rcnt <= rcnt + 4'd1;
      end
      if (rx_ten) ten <= 1'b1;
      if (rx_fin) begin
        bus.status <= err ? SD_ERR : rx_code;
        bus.done   <= 1'b1;
        state      <= ST_DONE;
      end
      if (rx_pass) begin
`ifdef SD_HOST_CHECK_EN
        idx   <= '0;
        row   <= '0;
        col   <= '0;
        state <= ST_CHECK;
`else
        bus.status <= err ? SD_ERR : SD_OK;
        bus.done   <= 1'b1;
        state      <= ST_DONE;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sd_host.sv
// Directed self-checking bench for sd_host: a vector table of board/response scenarios plus
// hand-written reset, readback and timeout sequences.
module tb_sd_host;
  import sd_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sd_host_if ifc();

  sd_host #(.NUM_BLANK(15), .TIMEOUT(50)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  localparam int B_STD = 0, B_DUP = 1, B_14 = 2;
  localparam int R_SOL = 0, R_TEN = 1, R_14 = 2, R_NONE = 3, R_BOX = 4, R_16 = 5,
                 R_ZERO = 6, R_ELEVEN = 7, R_TENMORE = 8, R_LATETEN = 9;
`ifdef SD_HOST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    int bmode;
    int rmode;
    bit send_err;
    int exp_status;
    int exp_lat;
  } vec_t;

  vec_t       vecs [12];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [3:0] exp_board [81];
  bit         done_seen;
  int         done_cyc;
  int         done_status;
  int         st, lat;

  always @(posedge clk) cyc <= cyc + 1;

  // known solution: a shifted-row Latin pattern that is a valid sudoku
  function automatic int sol_cell(input int i);
    int r, c;
    r = i / 9;
    c = i % 9;
    return ((r * 3 + r / 3 + c) % 9) + 1;
  endfunction

  function automatic bit is_blank(input int i);
    return (i % 5 == 2) && (i <= 72);
  endfunction

  function automatic int resp_len(input int m);
    case (m)
      R_TEN:     return 1;
      R_14:      return 14;
      R_NONE:    return 0;
      R_16:      return 16;
      R_TENMORE: return 2;
      default:   return 15;
    endcase
  endfunction

  function automatic int resp_val(input int m, input int j);
    int v;
    v = (j < 15) ? sol_cell(j * 5 + 2) : 9;
    case (m)
      R_TEN:     v = 10;
      R_BOX:     if (j == 6) v = 5;
      R_ZERO:    if (j == 3) v = 0;
      R_ELEVEN:  if (j == 0) v = 11;
      R_TENMORE: v = (j == 0) ? 10 : 3;
      R_LATETEN: if (j == 5) v = 10;
      default:   ;
    endcase
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (ifc.done === 1'b1) begin
      done_seen   = 1'b1;
      done_cyc    = cyc;
      done_status = int'(ifc.status);
    end
  endtask

  task automatic load_board(input int bmode);
    int v;
    for (int i = 0; i < 81; i++) begin
      v = is_blank(i) ? 0 : sol_cell(i);
      if (bmode == B_DUP && i == 0) v = 5;
      if (bmode == B_14 && i == 72) v = sol_cell(72);
      exp_board[i]   = 4'(v);
      ifc.load_valid = 1'b1;
      ifc.load_data  = 4'(v);
      tick();
    end
    ifc.load_valid = 1'b0;
    ifc.load_data  = 4'd0;
  endtask

  task automatic run(input string tag, input bit send_err, input int rmode, input bit start_load,
                     output int st_o, output int lat_o);
    int bad_cells, t_last, len;
    done_seen      = 1'b0;
    ifc.start      = 1'b1;
    ifc.load_valid = start_load;
    ifc.load_data  = 4'd7;
    tick();
    ifc.start      = 1'b0;
    ifc.load_valid = 1'b0;
    bad_cells = 0;
    for (int i = 0; i < 81; i++) begin
      if (!(ifc.sd_in_valid === 1'b1 && ifc.sd_in === exp_board[i] && ifc.busy === 1'b1))
        bad_cells++;
      ifc.sd_out_valid = send_err && (i == 40);
      ifc.sd_out       = 4'd3;
      tick();
    end
    ifc.sd_out_valid = 1'b0;
    check({tag, " stream"}, bad_cells, 0);
    check({tag, " in_valid/in after 81"}, int'({ifc.sd_in_valid, ifc.sd_in}), 0);
    t_last = cyc;
    len = resp_len(rmode);
    for (int j = 0; j < len; j++) begin
      ifc.sd_out_valid = 1'b1;
      ifc.sd_out       = 4'(resp_val(rmode, j));
      tick();
    end
    ifc.sd_out_valid = 1'b0;
    ifc.sd_out       = 4'd0;
    if (len > 0) t_last = cyc;
    for (int k = 0; k < 300 && !done_seen; k++) tick();
    check({tag, " done seen"}, int'(done_seen), 1);
    st_o  = done_seen ? done_status : -1;
    lat_o = done_seen ? done_cyc - t_last : -1;
    tick();
    tick();
    check({tag, " busy after done"}, int'(ifc.busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{B_STD, R_SOL,     1'b0, 0,         CHK ? 82 : 1};
    vecs[1]  = '{B_DUP, R_TEN,     1'b0, 1,         1};
    vecs[2]  = '{B_STD, R_14,      1'b0, 2,         1};
    vecs[3]  = '{B_STD, R_BOX,     1'b0, CHK ? 2 : 0, CHK ? 82 : 1};
    vecs[4]  = '{B_STD, R_16,      1'b0, 2,         -1};
    vecs[5]  = '{B_STD, R_ZERO,    1'b0, 2,         -1};
    vecs[6]  = '{B_STD, R_ELEVEN,  1'b0, 2,         -1};
    vecs[7]  = '{B_STD, R_TENMORE, 1'b0, 2,         -1};
    vecs[8]  = '{B_STD, R_LATETEN, 1'b0, 2,         -1};
    vecs[9]  = '{B_14,  R_SOL,     1'b0, 2,         1};
    vecs[10] = '{B_14,  R_TEN,     1'b0, 1,         1};
    vecs[11] = '{B_STD, R_SOL,     1'b1, 2,         CHK ? 82 : 1};

    rst = 1'b1;
    ifc.load_valid   = 1'b0;
    ifc.load_data    = 4'd0;
    ifc.start        = 1'b0;
    ifc.sd_out_valid = 1'b0;
    ifc.sd_out       = 4'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset busy", int'(ifc.busy), 0);
    check("reset sd_in_valid", int'(ifc.sd_in_valid), 0);
    check("reset sd_in", int'(ifc.sd_in), 0);
    check("reset done", int'(ifc.done), 0);
    check("reset status", int'(ifc.status), 0);

    for (int v = 0; v < 12; v++) begin
      load_board(vecs[v].bmode);
      run($sformatf("vec%0d", v), vecs[v].send_err, vecs[v].rmode, 1'b0, st, lat);
      check($sformatf("vec%0d status", v), st, vecs[v].exp_status);
      if (vecs[v].exp_lat >= 0)
        check($sformatf("vec%0d done latency", v), lat, vecs[v].exp_lat);
    end

    // solve, then rerun without loading: stream must read back the filled grid, then time out
    load_board(B_STD);
    run("solve", 1'b0, R_SOL, 1'b0, st, lat);
    check("solve status", st, 0);
    for (int i = 0; i < 81; i++) exp_board[i] = 4'(sol_cell(i));
    run("readback", 1'b0, R_NONE, 1'b0, st, lat);
    check("timeout status", st, 3);
    check("timeout latency from WAIT entry", lat, 50);

    // reset in the middle of SEND, then restart (with a dropped same-cycle load) on a cleared board
    load_board(B_STD);
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    rst = 1'b1;
    tick();
    check("mid-send reset sd_in_valid", int'(ifc.sd_in_valid), 0);
    check("mid-send reset busy", int'(ifc.busy), 0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 81; i++) exp_board[i] = 4'd0;
    run("after reset", 1'b0, R_TEN, 1'b1, st, lat);
    check("after reset status", st, 1);
    check("after reset latency", lat, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
